guess_scanner: RTL
==================

Name: guess_scanner

Overview:
- Reads back the secret word that the load path writes into the 32x5 word RAM (ram32x5, chars at addresses 1..word_len).
- Compares every stored character against the player-2 guess and reports match, hit count and hit positions.
- Keeps a revealed-position mask and the remaining-letter count for the fill-blank and win/lose logic.
- Sits between the word RAM read port and the game control FSM.

Parameters:
- CHAR_W, 5, width of one character code (1..26 = A..Z, 0 = unused).
- ADDR_W, 5, word RAM address width.
- MAX_LEN, 16, maximum word length; width of hit_mask and revealed.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous, active-high reset.
- new_word  in  1  1-cycle pulse; clears revealed state for a freshly loaded word.
- start  in  1  1-cycle pulse; begins a scan with the current guess.
- guess  in  CHAR_W  guessed character; sampled on the start edge.
- word_len  in  ADDR_W  number of stored characters; sampled on the start edge.
- rd_addr  out  ADDR_W  word RAM read address.
- rd_data  in  CHAR_W  word RAM q; synchronous read, 1-cycle latency.
- busy  out  1  scan in progress.
- done  out  1  1-cycle pulse; results valid.
- match  out  1  guess hit at least one not-yet-revealed position.
- dup  out  1  guess hit only already-revealed positions.
- count  out  ADDR_W  number of newly revealed positions this scan.
- hit_mask  out  MAX_LEN  newly revealed positions; bit k-1 = address k.
- revealed  out  MAX_LEN  cumulative revealed positions.
- remain  out  ADDR_W  word_len minus popcount(revealed).
- solved  out  1  remain == 0 at done.

Behaviour:
- Reset (async, whenever resetn high): state IDLE; all outputs and internal registers 0; rd_addr 0.
- Effective length: len = min(word_len, MAX_LEN).
- States:
  - IDLE: start & !busy → latch guess and len, clear count/hit_mask/match/dup, rd_addr <= 1, go to SCAN. start while busy is ignored.
  - SCAN: each cycle rd_addr increments by 1 while rd_addr < len, then holds. rd_data for address k is compared on edge start+1+k.
    - A position hits when rd_data == guess and guess != 0.
    - A hit on a position not in revealed sets hit_mask bit, increments count and sets match.
    - A hit on a position already in revealed sets an internal seen flag only.
    - After the compare for address len, go to FIN.
  - FIN: revealed <= revealed | hit_mask; remain updated; dup <= seen & !match; solved <= (remain_next == 0); done pulses for 1 cycle; return to IDLE.
- Latency: done is high in the cycle after edge start+len+2; busy is high from the start edge until done is asserted.
- len == 0: no compares; done at start+2; match 0; count 0; solved 1.
- guess == 0 never matches.
- new_word in IDLE clears revealed, remain, solved and dup. new_word while busy aborts the scan to IDLE with no done, then clears the same state.
- Reset asserted mid-scan aborts immediately: no done pulse, all state 0.
- match, dup, count and hit_mask hold their values until the next start.
- remain is computed at ADDR_W width and never underflows, because revealed is only set at positions below len.

Optional Feature:
- Macro GUESS_HISTORY_EN.
- Defined: a 27-bit used-letter register, cleared by reset and new_word.
  - start with an already-used guess skips the RAM scan: done at start+1, dup 1, match 0, count 0, hit_mask 0.
  - A first-time guess sets its used bit at FIN.
- Undefined: every start performs the full scan; repeat detection relies on the revealed mask only.

Test Plan:
- "CAT" (3,1,20) at addr 1..3, len 3; new_word; guess 1 → done at start+5, match 1, count 1, hit_mask 0x0002, remain 2, solved 0.
- "BOB" (2,15,2), len 3; guess 2 → count 2, hit_mask 0x0005, remain 1. Then guess 2 again → match 0, dup 1, count 0, remain 1. With GUESS_HISTORY_EN, the repeat's done arrives at start+1.
- "BOB": guess 2 then guess 15 → second scan count 1, hit_mask 0x0002, remain 0, solved 1.
- Reset pulse at start+2 of a len-3 scan → no done, all outputs 0. A following start scans normally.
- word_len 0; start → done at start+2, solved 1, count 0. word_len 20 → only addresses 1..16 read, done at start+18.
- start re-asserted while busy → ignored, single done. guess 0 on a word containing no 0s → match 0, dup 0.

Source files
------------

// File: rtl/guess_scanner.sv
// guess_scanner: reads the secret word back from the word RAM, compares every
// character with the guess and tracks revealed positions. Option: GUESS_HISTORY_EN.
module guess_scanner #(
  parameter int CHAR_W  = 5,
  parameter int ADDR_W  = 5,
  parameter int MAX_LEN = 16
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               new_word,
  input  logic               start,
  input  logic [CHAR_W-1:0]  guess,
  input  logic [ADDR_W-1:0]  word_len,
  output logic [ADDR_W-1:0]  rd_addr,
  input  logic [CHAR_W-1:0]  rd_data,
  output logic               busy,
  output logic               done,
  output logic               match,
  output logic               dup,
  output logic [ADDR_W-1:0]  count,
  output logic [MAX_LEN-1:0] hit_mask,
  output logic [MAX_LEN-1:0] revealed,
  output logic [ADDR_W-1:0]  remain,
  output logic               solved
);

  localparam logic [ADDR_W-1:0]  MAX_LEN_A = ADDR_W'(MAX_LEN);
  localparam logic [ADDR_W-1:0]  ZERO_A    = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0]  ONE_A     = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [MAX_LEN-1:0] ZERO_M    = {MAX_LEN{1'b0}};
  localparam logic [MAX_LEN-1:0] ONE_M     = {{(MAX_LEN-1){1'b0}}, 1'b1};
  localparam logic [CHAR_W-1:0]  ZERO_C    = {CHAR_W{1'b0}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    FIN    = 2'd2,
    REPEAT = 2'd3
  } state_t;

  function automatic logic [ADDR_W-1:0] popcount(input logic [MAX_LEN-1:0] v);
    logic [ADDR_W-1:0] n;
    n = ZERO_A;
    for (int i = 0; i < MAX_LEN; i++) begin
      n = n + ADDR_W'(v[i]);
    end
    return n;
  endfunction

  state_t              state_r, state_s;
  logic [CHAR_W-1:0]   guess_r;
  logic [ADDR_W-1:0]   len_r;
  logic [ADDR_W-1:0]   step_r;
  logic                seen_r;
  logic [ADDR_W-1:0]   rd_addr_r;
  logic                busy_r;
  logic                done_r;
  logic                match_r;
  logic                dup_r;
  logic [ADDR_W-1:0]   count_r;
  logic [MAX_LEN-1:0]  hit_mask_r;
  logic [MAX_LEN-1:0]  revealed_r;
  logic [ADDR_W-1:0]   remain_r;
  logic                solved_r;

  logic [ADDR_W-1:0]   len_s;
  logic                start_ok_s;
  logic                hit_s;
  logic                repeat_s;
  logic [MAX_LEN-1:0]  pos_s;
  logic [MAX_LEN-1:0]  revealed_next_s;
  logic [ADDR_W-1:0]   remain_next_s;
`ifdef GUESS_HISTORY_EN
  logic [26:0]         used_r;
  logic [26:0]         guess_bit_s;
  logic [26:0]         used_set_s;
`endif

  // Scan helpers: clipped length, compare result and the one-hot position under test
  always_comb begin
    len_s           = (word_len > MAX_LEN_A) ? MAX_LEN_A : word_len;
    start_ok_s      = start & ~new_word & (state_r == IDLE);
    hit_s           = (rd_data == guess_r) && (guess_r != ZERO_C);
    pos_s           = ONE_M << (step_r - ONE_A);
    revealed_next_s = revealed_r | hit_mask_r;
    remain_next_s   = len_r - popcount(revealed_next_s);
`ifdef GUESS_HISTORY_EN
    guess_bit_s     = 27'd1 << guess;
    used_set_s      = 27'd1 << guess_r;
    repeat_s        = |(used_r & guess_bit_s);
`else
    repeat_s        = 1'b0;
`endif
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_ok_s) begin
          state_s = repeat_s ? REPEAT : SCAN;
        end else begin
          state_s = IDLE;
        end
      end
      SCAN: begin
        if (new_word) begin
          state_s = IDLE;
        end else if (step_r == len_r) begin
          state_s = FIN;
        end else begin
          state_s = SCAN;
        end
      end
      FIN:     state_s = IDLE;
      REPEAT:  state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath: step counter lags rd_addr by one because the RAM read takes a cycle
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      guess_r    <= ZERO_C;
      len_r      <= ZERO_A;
      step_r     <= ZERO_A;
      seen_r     <= 1'b0;
      rd_addr_r  <= ZERO_A;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      match_r    <= 1'b0;
      dup_r      <= 1'b0;
      count_r    <= ZERO_A;
      hit_mask_r <= ZERO_M;
      revealed_r <= ZERO_M;
      remain_r   <= ZERO_A;
      solved_r   <= 1'b0;
`ifdef GUESS_HISTORY_EN
      used_r     <= 27'd0;
`endif
    end else begin
      done_r <= 1'b0;
      if (new_word) begin
        busy_r     <= 1'b0;
        revealed_r <= ZERO_M;
        remain_r   <= ZERO_A;
        solved_r   <= 1'b0;
        dup_r      <= 1'b0;
`ifdef GUESS_HISTORY_EN
        used_r     <= 27'd0;
`endif
      end else begin
        case (state_r)
          IDLE: begin
            if (start_ok_s) begin
              guess_r    <= guess;
              len_r      <= len_s;
              step_r     <= ZERO_A;
              seen_r     <= 1'b0;
              count_r    <= ZERO_A;
              hit_mask_r <= ZERO_M;
              match_r    <= 1'b0;
              dup_r      <= 1'b0;
              rd_addr_r  <= ONE_A;
              busy_r     <= 1'b1;
            end
          end
          SCAN: begin
            if (rd_addr_r < len_r) begin
              rd_addr_r <= rd_addr_r + ONE_A;
            end
            if ((step_r != ZERO_A) && hit_s) begin
              if (|(revealed_r & pos_s)) begin
                seen_r <= 1'b1;
              end else begin
                hit_mask_r <= hit_mask_r | pos_s;
                count_r    <= count_r + ONE_A;
                match_r    <= 1'b1;
              end
            end
            if (step_r != len_r) begin
              step_r <= step_r + ONE_A;
            end
          end
          FIN: begin
            revealed_r <= revealed_next_s;
            remain_r   <= remain_next_s;
            solved_r   <= (remain_next_s == ZERO_A);
            dup_r      <= seen_r & ~match_r;
            done_r     <= 1'b1;
            busy_r     <= 1'b0;
`ifdef GUESS_HISTORY_EN
            used_r     <= used_r | used_set_s;
`endif
          end
          REPEAT: begin
            dup_r  <= 1'b1;
            done_r <= 1'b1;
            busy_r <= 1'b0;
          end
          default: begin
            busy_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rd_addr  = rd_addr_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign match    = match_r;
  assign dup      = dup_r;
  assign count    = count_r;
  assign hit_mask = hit_mask_r;
  assign revealed = revealed_r;
  assign remain   = remain_r;
  assign solved   = solved_r;

endmodule
